// File: rtl/rr_recovery_ctrl.sv
// Rename History Table pointer owner and flush-recovery sequencer: walks squashed
// RHT entries youngest-first, restoring RAT mappings and returning pregs to the free list.
module rr_recovery_ctrl #(
    parameter int P_REGISTERS = 64,
    parameter int L_REGISTERS = 32,
    parameter int C_NUM       = 4,
    parameter int K           = 32,
    parameter int INSTR_COUNT = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(INSTR_COUNT+1)-1:0]   alloc_cnt,
    input  logic [$clog2(INSTR_COUNT+1)-1:0]   commit_cnt,
    input  logic                               flush_en,
    input  logic [$clog2(C_NUM*K)-1:0]         flush_rht_id,
    output logic [$clog2(C_NUM*K)-1:0]         rht_tail,
    output logic [$clog2(C_NUM*K)-1:0]         rht_head,
    output logic [$clog2(C_NUM*K):0]           rht_count,
    output logic                               rht_ready,
    output logic                               rht_rd_en,
    output logic [$clog2(C_NUM*K)-1:0]         rht_rd_addr,
    input  logic                               rht_rd_valid,
    input  logic [$clog2(L_REGISTERS)-1:0]     rht_rd_lreg,
    input  logic [$clog2(P_REGISTERS)-1:0]     rht_rd_preg,
    input  logic [$clog2(P_REGISTERS)-1:0]     rht_rd_ppreg,
    output logic                               rat_wr_en,
    output logic [$clog2(L_REGISTERS)-1:0]     rat_wr_lreg,
    output logic [$clog2(P_REGISTERS)-1:0]     rat_wr_preg,
    output logic                               fl_push_en,
    output logic [$clog2(P_REGISTERS)-1:0]     fl_push_preg,
    output logic                               rec_busy,
    output logic                               rec_done,
    output logic                               flush_err
);

    localparam int DEPTH = C_NUM * K;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - INSTR_COUNT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [AW:0]    count_q, count_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  stop_q, stop_d;
    logic           rd_pend_q, rd_pend_d;
    logic           rec_busy_q, rec_busy_d;
    logic           rec_done_q, rec_done_d;
    logic           flush_err_q, flush_err_d;

    logic [AW-1:0]  alloc_a, commit_a, flush_off;
    logic [AW:0]    alloc_w, commit_w;
    logic           in_range, is_empty;

    assign alloc_a   = AW'(alloc_cnt);
    assign commit_a  = AW'(commit_cnt);
    assign alloc_w   = (AW+1)'(alloc_cnt);
    assign commit_w  = (AW+1)'(commit_cnt);

    // Distance from head decides membership; count_q covers the full case where head == tail.
    assign flush_off = flush_rht_id - head_q;
    assign in_range  = ({1'b0, flush_off} < count_q);
    assign is_empty  = ({1'b0, flush_off} == count_q);

    assign rht_ready = (count_q <= READY_MAX) && !rec_busy_q;

    always_comb begin
        state_d     = state_q;
        head_d      = head_q + commit_a;
        tail_d      = tail_q;
        count_d     = count_q - commit_w;
        rd_ptr_d    = rd_ptr_q;
        stop_d      = stop_q;
        rd_pend_d   = 1'b0;
        rec_busy_d  = rec_busy_q;
        rec_done_d  = 1'b0;
        flush_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_en) begin
                    if (in_range) begin
                        state_d    = S_WALK;
                        rd_ptr_d   = tail_q - 1'b1;
                        stop_d     = flush_rht_id;
                        rec_busy_d = 1'b1;
                    end else if (is_empty) begin
                        rec_done_d = 1'b1;
                    end else begin
                        flush_err_d = 1'b1;
                    end
                end else if (rht_ready) begin
                    tail_d  = tail_q + alloc_a;
                    count_d = count_q + alloc_w - commit_w;
                end
            end
            S_WALK: begin
                rd_pend_d   = 1'b1;
                flush_err_d = flush_en;
                if (rd_ptr_q == stop_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_ptr_d = rd_ptr_q - 1'b1;
                end
            end
            S_DRAIN: begin
                state_d     = S_IDLE;
                tail_d      = stop_q;
                count_d     = {1'b0, stop_q - head_d};
                rec_busy_d  = 1'b0;
                rec_done_d  = 1'b1;
                flush_err_d = flush_en;
            end
            default: begin
                state_d    = S_IDLE;
                rec_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            stop_q      <= '0;
            rd_pend_q   <= 1'b0;
            rec_busy_q  <= 1'b0;
            rec_done_q  <= 1'b0;
            flush_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            stop_q      <= stop_d;
            rd_pend_q   <= rd_pend_d;
            rec_busy_q  <= rec_busy_d;
            rec_done_q  <= rec_done_d;
            flush_err_q <= flush_err_d;
        end
    end

    assign rht_tail     = tail_q;
    assign rht_head     = head_q;
    assign rht_count    = count_q;
    assign rht_rd_en    = (state_q == S_WALK);
    assign rht_rd_addr  = rd_ptr_q;
    // Read data lands one cycle after the strobe; rd_pend_q marks that return cycle.
    assign rat_wr_en    = rd_pend_q & rht_rd_valid;
    assign rat_wr_lreg  = rht_rd_lreg;
    assign rat_wr_preg  = rht_rd_ppreg;
    assign fl_push_en   = rd_pend_q & rht_rd_valid;
    assign fl_push_preg = rht_rd_preg;
    assign rec_busy     = rec_busy_q;
    assign rec_done     = rec_done_q;
    assign flush_err    = flush_err_q;

    a_alloc_when_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (alloc_cnt != '0) |-> rht_ready);

endmodule

// File: tb/tb_rr_recovery_ctrl.sv
// Bench for rr_recovery_ctrl: table of pointer vectors, directed flush sequences and a
// randomized run scored against a position-based RHT model with a memory responder.
module tb_rr_recovery_ctrl;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int CW    = 2;
    localparam int LW    = 5;
    localparam int PW    = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] alloc_cnt = '0;
    logic [CW-1:0] commit_cnt = '0;
    logic          flush_en = 1'b0;
    logic [AW-1:0] flush_rht_id = '0;
    logic [AW-1:0] rht_tail, rht_head, rht_rd_addr;
    logic [AW:0]   rht_count;
    logic          rht_ready, rht_rd_en, rht_rd_valid;
    logic [LW-1:0] rht_rd_lreg, rat_wr_lreg;
    logic [PW-1:0] rht_rd_preg, rht_rd_ppreg, rat_wr_preg, fl_push_preg;
    logic          rat_wr_en, fl_push_en, rec_busy, rec_done, flush_err;

    always #5 clk = ~clk;

    rr_recovery_ctrl #(
        .P_REGISTERS(64), .L_REGISTERS(32), .C_NUM(4), .K(32), .INSTR_COUNT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .alloc_cnt(alloc_cnt), .commit_cnt(commit_cnt),
        .flush_en(flush_en), .flush_rht_id(flush_rht_id), .rht_tail(rht_tail),
        .rht_head(rht_head), .rht_count(rht_count), .rht_ready(rht_ready),
        .rht_rd_en(rht_rd_en), .rht_rd_addr(rht_rd_addr), .rht_rd_valid(rht_rd_valid),
        .rht_rd_lreg(rht_rd_lreg), .rht_rd_preg(rht_rd_preg), .rht_rd_ppreg(rht_rd_ppreg),
        .rat_wr_en(rat_wr_en), .rat_wr_lreg(rat_wr_lreg), .rat_wr_preg(rat_wr_preg),
        .fl_push_en(fl_push_en), .fl_push_preg(fl_push_preg), .rec_busy(rec_busy),
        .rec_done(rec_done), .flush_err(flush_err)
    );

    // RHT contents served by the bench with one cycle of read latency
    logic          mem_v [DEPTH];
    logic [LW-1:0] mem_l [DEPTH];
    logic [PW-1:0] mem_p [DEPTH];
    logic [PW-1:0] mem_pp[DEPTH];

    always @(posedge clk) begin
        if (!rst_n) begin
            rht_rd_valid <= 1'b0;
            rht_rd_lreg  <= '0;
            rht_rd_preg  <= '0;
            rht_rd_ppreg <= '0;
        end else if (rht_rd_en) begin
            rht_rd_valid <= mem_v[rht_rd_addr];
            rht_rd_lreg  <= mem_l[rht_rd_addr];
            rht_rd_preg  <= mem_p[rht_rd_addr];
            rht_rd_ppreg <= mem_pp[rht_rd_addr];
        end else begin
            rht_rd_valid <= 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;
    int m_head, m_tail, m_count;
    logic [AW-1:0] exp_rd_q[$];
    logic [16:0]   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: read addresses and restore/push records in issue order
    always @(negedge clk) begin
        logic [16:0] got;
        if (rst_n) begin
            if (rht_rd_en) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: read of addr %0d, none expected", rht_rd_addr);
                end else begin
                    chk("rd_addr", rht_rd_addr, exp_rd_q.pop_front());
                end
            end
            if (rat_wr_en || fl_push_en) begin
                got = {rat_wr_lreg, rat_wr_preg, fl_push_preg};
                chk("rat_wr_en", rat_wr_en, 1);
                chk("fl_push_en", fl_push_en, 1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL restore_unexpected: record %h, none expected", got);
                end else begin
                    chk("restore_rec", got, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ptrs(input string tag);
        chk({tag, "_head"}, rht_head, m_head);
        chk({tag, "_tail"}, rht_tail, m_tail);
        chk({tag, "_count"}, rht_count, m_count);
        chk({tag, "_ready"}, rht_ready, (m_count <= DEPTH - 2) ? 1 : 0);
    endtask

    task automatic idle_cycle(input int a, input int c);
        alloc_cnt = CW'(a);
        commit_cnt = CW'(c);
        step();
        alloc_cnt = '0;
        commit_cnt = '0;
        m_tail = (m_tail + a) % DEPTH;
        m_head = (m_head + c) % DEPTH;
        m_count = m_count + a - c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_cnt = '0;
        commit_cnt = '0;
        flush_en = 1'b0;
        flush_rht_id = '0;
        exp_q.delete();
        exp_rd_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        m_head = 0; m_tail = 0; m_count = 0;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int e = 0; e < DEPTH; e++) begin
            if (rnd) begin
                mem_v[e]  = ($urandom_range(0, 4) != 0);
                mem_l[e]  = LW'($urandom_range(0, 31));
                mem_p[e]  = PW'($urandom_range(0, 63));
                mem_pp[e] = PW'($urandom_range(0, 63));
            end else begin
                mem_v[e]  = 1'b1;
                mem_l[e]  = LW'(e % 32);
                mem_p[e]  = PW'(e % 64);
                mem_pp[e] = PW'((e + 7) % 64);
            end
        end
    endtask

    // mid_req: -1 none, >=0 loop index for a second flush, -2 random within the walk
    task automatic do_flush(input int id, input int c0_req, input bit walk_commit, input int mid_req);
        int p, n, c0, c, lim, com_total, busy, mid_at, e;
        bit done;
        p = -1;
        for (int i = 0; i < m_count; i++) begin
            if (((m_head + i) % DEPTH) == id) begin
                p = i;
                break;
            end
        end
        flush_en = 1'b1;
        flush_rht_id = AW'(id);
        alloc_cnt = '0;
        commit_cnt = '0;
        if (p >= 0) begin
            n = m_count - p;
            c0 = c0_req;
            if (c0 > p) c0 = p;
            if (c0 > 2) c0 = 2;
            mid_at = (mid_req == -2) ? int'($urandom_range(0, n)) : mid_req;
            for (int j = 0; j < n; j++) begin
                e = (m_tail - 1 - j + DEPTH) % DEPTH;
                exp_rd_q.push_back(AW'(e));
                if (mem_v[e]) exp_q.push_back({mem_l[e], mem_pp[e], mem_p[e]});
            end
            commit_cnt = CW'(c0);
            step();
            flush_en = 1'b0;
            commit_cnt = '0;
            m_head = (m_head + c0) % DEPTH;
            com_total = c0;
            busy = 0;
            done = 1'b0;
            for (int k = 0; k < 400; k++) begin
                if (rec_done) begin
                    done = 1'b1;
                    break;
                end
                if (rec_busy) busy++;
                c = 0;
                if (walk_commit && com_total < p) begin
                    lim = p - com_total;
                    if (lim > 2) lim = 2;
                    c = $urandom_range(0, lim);
                end
                commit_cnt = CW'(c);
                if (k == mid_at) begin
                    flush_en = 1'b1;
                    flush_rht_id = AW'($urandom_range(0, DEPTH - 1));
                end
                step();
                commit_cnt = '0;
                m_head = (m_head + c) % DEPTH;
                com_total += c;
                if (k == mid_at) begin
                    flush_en = 1'b0;
                    chk("mid_walk_flush_err", flush_err, 1);
                end
            end
            chk("walk_done_seen", done, 1);
            chk("busy_cycles", busy, n + 1);
            m_tail = id;
            m_count = p - com_total;
            chk("reads_left", exp_rd_q.size(), 0);
            chk("restores_left", exp_q.size(), 0);
            check_ptrs("after_walk");
            chk("busy_after_walk", rec_busy, 0);
            step();
            chk("done_pulse_end", rec_done, 0);
        end else if (id == m_tail) begin
            c0 = c0_req;
            if (c0 > m_count) c0 = m_count;
            if (c0 > 2) c0 = 2;
            commit_cnt = CW'(c0);
            step();
            flush_en = 1'b0;
            commit_cnt = '0;
            m_head = (m_head + c0) % DEPTH;
            m_count = m_count - c0;
            chk("empty_done", rec_done, 1);
            chk("empty_busy", rec_busy, 0);
            chk("empty_err", flush_err, 0);
            check_ptrs("empty_flush");
            step();
            chk("empty_done_end", rec_done, 0);
            chk("empty_busy_end", rec_busy, 0);
        end else begin
            step();
            flush_en = 1'b0;
            chk("range_err", flush_err, 1);
            chk("range_err_busy", rec_busy, 0);
            chk("range_err_done", rec_done, 0);
            check_ptrs("range_err");
            step();
            chk("range_err_end", flush_err, 0);
        end
    endtask

    typedef struct {
        int alloc;
        int commit;
        int tail;
        int head;
        int count;
        int ready;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int a, c, id, lim;
        vecs[0] = '{2, 0, 2, 0, 2, 1};
        vecs[1] = '{2, 0, 4, 0, 4, 1};
        vecs[2] = '{2, 0, 6, 0, 6, 1};
        vecs[3] = '{2, 0, 8, 0, 8, 1};
        vecs[4] = '{0, 1, 8, 1, 7, 1};
        vecs[5] = '{0, 1, 8, 2, 6, 1};
        vecs[6] = '{0, 1, 8, 3, 5, 1};
        vecs[7] = '{1, 2, 9, 5, 4, 1};

        fill_mem(1'b0);
        do_reset();
        chk("rst_head", rht_head, 0);
        chk("rst_tail", rht_tail, 0);
        chk("rst_count", rht_count, 0);
        chk("rst_ready", rht_ready, 1);
        chk("rst_busy", rec_busy, 0);
        chk("rst_done", rec_done, 0);
        chk("rst_err", flush_err, 0);
        chk("rst_rd_en", rht_rd_en, 0);
        chk("rst_rat_wr", rat_wr_en, 0);

        for (int i = 0; i < 8; i++) begin
            idle_cycle(vecs[i].alloc, vecs[i].commit);
            chk("tbl_tail", rht_tail, vecs[i].tail);
            chk("tbl_head", rht_head, vecs[i].head);
            chk("tbl_count", rht_count, vecs[i].count);
            chk("tbl_ready", rht_ready, vecs[i].ready);
        end

        // Basic flush: entries 7,6,5
        do_reset();
        repeat (4) idle_cycle(2, 0);
        do_flush(5, 0, 1'b0, -1);
        chk("basic_tail", rht_tail, 5);
        chk("basic_count", rht_count, 5);

        // Entry 6 has no destination
        idle_cycle(2, 0);
        idle_cycle(1, 0);
        mem_v[6] = 1'b0;
        do_flush(4, 0, 1'b0, -1);
        mem_v[6] = 1'b1;
        do_flush(4, 1, 1'b0, -1);
        do_flush(20, 0, 1'b0, -1);

        // Wrap: head=120, tail=4
        do_reset();
        repeat (62) idle_cycle(2, 0);
        repeat (4) idle_cycle(2, 2);
        repeat (56) idle_cycle(0, 2);
        check_ptrs("wrap_setup");
        do_flush(126, 0, 1'b0, -1);
        chk("wrap_tail", rht_tail, 126);
        chk("wrap_count", rht_count, 6);
        do_flush(126, 0, 1'b0, -1);
        do_flush(0, 0, 1'b0, -1);

        // Full RHT flushed from head, with a second flush mid-walk
        do_reset();
        repeat (64) idle_cycle(2, 0);
        chk("full_count", rht_count, 128);
        chk("full_ready", rht_ready, 0);
        do_flush(0, 0, 1'b0, 10);
        chk("full_after_count", rht_count, 0);
        chk("full_after_tail", rht_tail, 0);

        // Reset in the middle of a walk
        do_reset();
        repeat (5) idle_cycle(2, 0);
        for (int j = 0; j < 8; j++) begin
            exp_rd_q.push_back(AW'(9 - j));
            exp_q.push_back({mem_l[9 - j], mem_pp[9 - j], mem_p[9 - j]});
        end
        flush_en = 1'b1;
        flush_rht_id = AW'(2);
        step();
        flush_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        exp_q.delete();
        exp_rd_q.delete();
        #1;
        chk("mid_rst_rat_wr", rat_wr_en, 0);
        chk("mid_rst_fl_push", fl_push_en, 0);
        chk("mid_rst_rd_en", rht_rd_en, 0);
        chk("mid_rst_busy", rec_busy, 0);
        chk("mid_rst_tail", rht_tail, 0);
        chk("mid_rst_head", rht_head, 0);
        chk("mid_rst_count", rht_count, 0);
        step();
        chk("mid_rst_rat_wr_hold", rat_wr_en, 0);
        rst_n = 1'b1;
        step();
        m_head = 0; m_tail = 0; m_count = 0;
        check_ptrs("mid_rst_release");
        repeat (3) step();

        // Randomized traffic against the model
        fill_mem(1'b1);
        do_reset();
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 99) < 6) begin
                if (m_count > 0 && $urandom_range(0, 3) != 0)
                    id = (m_head + $urandom_range(0, m_count - 1)) % DEPTH;
                else
                    id = $urandom_range(0, DEPTH - 1);
                do_flush(id, $urandom_range(0, 2), 1'b1, ($urandom_range(0, 3) == 0) ? -2 : -1);
            end else begin
                a = (m_count <= DEPTH - 2) ? int'($urandom_range(0, 2)) : 0;
                lim = (m_count < 2) ? m_count : 2;
                c = $urandom_range(0, lim);
                if ($urandom_range(0, 2) == 0) c = 0;
                idle_cycle(a, c);
                check_ptrs("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_recovery_ctrl.md
Name: rr_recovery_ctrl

Overview:
Sequencer for the rename stage's Rename History Table (RHT, C_NUM*K entries, circular). It owns the RHT head/tail/occupancy pointers and, on a flush, walks the RHT youngest-first. For each squashed entry it restores the RAT mapping (lreg <- ppreg) and returns the squashed preg to the free list. rec_busy stalls the rename front end for the duration of the walk.

Parameters:
P_REGISTERS, 64, physical registers
L_REGISTERS, 32, logical registers
C_NUM, 4, checkpoint count; RHT depth DEPTH = C_NUM*K, which must be a power of two
K, 32, entries per checkpoint slice
INSTR_COUNT, 2, rename width (maximum RHT allocations and commits per cycle)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_cnt  in  $clog2(INSTR_COUNT+1)  RHT entries allocated this cycle, written at tail..tail+alloc_cnt-1
commit_cnt  in  $clog2(INSTR_COUNT+1)  RHT entries retired from head this cycle
flush_en  in  1  recovery request
flush_rht_id  in  $clog2(C_NUM*K)  oldest RHT entry to squash
rht_tail  out  $clog2(C_NUM*K)  next alloc_rht_id
rht_head  out  $clog2(C_NUM*K)  oldest live entry
rht_count  out  $clog2(C_NUM*K)+1  occupancy
rht_ready  out  1  rht_count <= DEPTH-INSTR_COUNT and !rec_busy
rht_rd_en  out  1  RHT read strobe
rht_rd_addr  out  $clog2(C_NUM*K)  RHT read index
rht_rd_valid  in  1  entry has a destination (returned 1 cycle after rd_en)
rht_rd_lreg  in  $clog2(L_REGISTERS)  entry lreg (1-cycle read latency)
rht_rd_preg  in  $clog2(P_REGISTERS)  preg allocated by the entry
rht_rd_ppreg  in  $clog2(P_REGISTERS)  previous mapping
rat_wr_en  out  1  RAT restore strobe
rat_wr_lreg  out  $clog2(L_REGISTERS)  RAT index
rat_wr_preg  out  $clog2(P_REGISTERS)  restored mapping (ppreg)
fl_push_en  out  1  free-list return strobe
fl_push_preg  out  $clog2(P_REGISTERS)  freed preg
rec_busy  out  1  recovery in progress
rec_done  out  1  1-cycle pulse at end of recovery
flush_err  out  1  1-cycle pulse when a flush is rejected

Behaviour:
- Reset (async, rst_n=0): head=tail=count=0; FSM=IDLE; all strobes and outputs 0; rht_ready=1.
- Pointer arithmetic is mod DEPTH (natural wrap). count = tail-head, with explicit full tracking so count=DEPTH is representable.
- IDLE:
  - tail += alloc_cnt; head += commit_cnt; count updates by the net amount; all take effect the next cycle.
  - alloc_cnt>0 while !rht_ready is a protocol violation (assertion); the allocation is dropped.
- Flush acceptance (IDLE only):
  - flush_rht_id must lie within [head, tail) modulo DEPTH. Otherwise flush_err=1 next cycle and the state is unchanged.
  - flush_rht_id == tail (empty range): no walk; rec_done=1 next cycle; rec_busy stays 0.
  - Valid non-empty range: rd_ptr <= tail-1; stop <= flush_rht_id; FSM -> WALK; rec_busy=1 from the next cycle.
  - alloc_cnt in the same cycle as an accepted flush is discarded. commit_cnt in that cycle is still applied.
- WALK:
  - Each cycle: rht_rd_en=1, rht_rd_addr=rd_ptr.
  - If rd_ptr==stop -> DRAIN; else rd_ptr-1.
  - The read issued in cycle t returns in t+1. If rht_rd_valid, then in t+1: rat_wr_en=1, rat_wr_lreg=lreg, rat_wr_preg=ppreg, fl_push_en=1, fl_push_preg=preg. If !rht_rd_valid, no restore and no push.
  - Restores therefore occur strictly youngest-first, one per cycle.
- DRAIN (1 cycle): last restore/push; tail <= stop; count recomputed; FSM -> IDLE; rec_done=1 and rec_busy=0 from the next cycle.
- Latency: N squashed entries -> rec_busy high for N+1 cycles.
- During WALK/DRAIN:
  - commit_cnt is still honoured (commits are older than the flush point, so head never crosses stop).
  - alloc_cnt is ignored (assertion).
  - flush_en is rejected with flush_err.
- Reset mid-walk: immediate return to the reset state. No further RAT or free-list strobes are issued.
- A flush covering the full RHT (count=DEPTH, flush_rht_id=head) walks DEPTH entries and ends with tail=head, count=0.

Test Plan:
- Reset, then alloc_cnt=2 for 4 cycles -> rht_tail=8, rht_count=8; commit_cnt=1 for 3 cycles -> rht_head=3, count=5.
- Tail=8, head=0; flush_rht_id=5 -> reads at addr 7,6,5; RAT restores for entries 7,6,5 in that order; rec_busy high 4 cycles; rec_done pulse; rht_tail=5, rht_count=5.
- Wrap case: head=120, tail=4 (count=12); flush_rht_id=126 -> reads 3,2,1,0,127,126; final tail=126, count=6.
- Entry 6 with rht_rd_valid=0 inside a flush range -> no rat_wr_en or fl_push_en in its return cycle; the neighbouring entries are restored normally.
- flush_rht_id=tail -> no reads, rec_busy stays 0, rec_done next cycle. flush_rht_id outside [head,tail) -> flush_err pulse, pointers unchanged.
- Full RHT (count=128) flushed from head -> 128 restores, count=0. A second flush_en mid-walk -> flush_err. rst_n low mid-walk -> strobes stop at once, all pointers 0.
